// File: rtl/niosqsys_ocimem_pkg.sv
// Shared types and constants for the OCI debug-memory arbiter.
package niosqsys_ocimem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    J_ISSUE = 3'd1,
    J_CAP   = 3'd2,
    J_DONE  = 3'd3,
    A_ISSUE = 3'd4,
    A_CAP   = 3'd5
  } ocimem_state_t;

  localparam logic GRANT_AVS  = 1'b0;
  localparam logic GRANT_JTAG = 1'b1;

  // True while a JTAG access owns the RAM (issue through completion).
  function automatic logic is_jtag_state(input ocimem_state_t s);
    return (s == J_ISSUE) || (s == J_CAP) || (s == J_DONE);
  endfunction

endpackage

// File: rtl/niosqsys_ocimem_jtag_slot.sv
// JTAG side of the arbiter: one-entry request slot, MonAReg with
// post-access increment, and the sticky overrun flag.
module niosqsys_ocimem_jtag_slot #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_ld_addr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  input  logic              jtag_clr_err,
  input  logic              jtag_busy,
  input  logic              slot_take,
  input  logic              addr_inc,
  output logic              slot_full,
  output logic              slot_wr,
  output logic [DATA_W-1:0] slot_wdata,
  output logic [ADDR_W-1:0] mon_a_reg,
  output logic              jtag_overrun
);

  logic blocked;
  logic accept_req;
  logic accept_ld;
  logic drop;

  // While anything is queued or in flight, MonAReg and the slot are frozen;
  // any new pulse is lost and flagged instead.
  assign blocked    = slot_full | jtag_busy;
  assign accept_req = jtag_req & ~blocked;
  assign accept_ld  = jtag_ld_addr & ~blocked;
  assign drop       = (jtag_req | jtag_ld_addr) & blocked;

  // Pending slot: filled by an accepted request, emptied when the FSM issues it.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_full  <= 1'b0;
      slot_wr    <= 1'b0;
      slot_wdata <= '0;
    end else if (accept_req) begin
      slot_full  <= 1'b1;
      slot_wr    <= jtag_wr;
      slot_wdata <= jtag_wdata;
    end else if (slot_take) begin
      slot_full  <= 1'b0;
    end
  end

  // MonAReg: explicit load, or wrap-around increment after each completed access.
  always_ff @(posedge clk) begin
    if (reset) begin
      mon_a_reg <= '0;
    end else if (accept_ld) begin
      mon_a_reg <= jtag_addr;
    end else if (addr_inc) begin
      mon_a_reg <= mon_a_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      jtag_overrun <= 1'b0;
    end else if (drop) begin
      jtag_overrun <= 1'b1;
    end else if (jtag_clr_err) begin
      jtag_overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/niosqsys_ocimem_arbiter.sv
// Arbitrates the single-port debug RAM between JTAG action pulses and the
// Avalon debug slave. Every access returns through IDLE.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | no access; pick JTAG slot and/or Avalon command (round robin on collision)
// J_ISSUE | drive MonAReg (and write data) to RAM, free the slot
// J_CAP   | RAM read data valid, capture into MonDReg
// J_DONE  | pulse jtag_done, advance MonAReg
// A_ISSUE | drive Avalon address; a write completes here
// A_CAP   | RAM read data valid, returned on avs_readdata
module niosqsys_ocimem_arbiter
  import niosqsys_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_ld_addr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  input  logic              jtag_clr_err,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_done,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  ocimem_state_t state, state_nxt;
  logic          last_grant;
  logic          grant_upd;
  logic          slot_full;
  logic          slot_wr;
  logic [DATA_W-1:0] slot_wdata;
  logic [ADDR_W-1:0] mon_a_reg;
  logic          slot_take;
  logic          avs_complete;
  logic          avs_cmd;

  assign avs_cmd = avs_read | avs_write;

  niosqsys_ocimem_jtag_slot #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_jtag_slot (
    .clk          (clk),
    .reset        (reset),
    .jtag_ld_addr (jtag_ld_addr),
    .jtag_addr    (jtag_addr),
    .jtag_req     (jtag_req),
    .jtag_wr      (jtag_wr),
    .jtag_wdata   (jtag_wdata),
    .jtag_clr_err (jtag_clr_err),
    .jtag_busy    (is_jtag_state(state)),
    .slot_take    (slot_take),
    .addr_inc     (state == J_DONE),
    .slot_full    (slot_full),
    .slot_wr      (slot_wr),
    .slot_wdata   (slot_wdata),
    .mon_a_reg    (mon_a_reg),
    .jtag_overrun (jtag_overrun)
  );

  // State register and round-robin memory; last_grant only moves on a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_AVS;
    end else begin
      state <= state_nxt;
      if (grant_upd) begin
        last_grant <= (state_nxt == J_ISSUE) ? GRANT_JTAG : GRANT_AVS;
      end
    end
  end

  // JTAG readback register, loaded the cycle RAM data is valid for a JTAG read.
  always_ff @(posedge clk) begin
    if (reset) begin
      MonDReg <= '0;
    end else if (state == J_CAP) begin
      MonDReg <= ram_rdata;
    end
  end

  // Next-state and output decode; RAM port is driven only from state and registers,
  // except Avalon operands which pass through in A_ISSUE.
  always_comb begin
    state_nxt    = state;
    grant_upd    = 1'b0;
    ram_addr     = '0;
    ram_we       = 1'b0;
    ram_wdata    = '0;
    avs_complete = 1'b0;
    avs_readdata = '0;
    slot_take    = 1'b0;
    jtag_done    = 1'b0;
    case (state)
      IDLE: begin
        if (slot_full && avs_cmd) begin
          grant_upd = 1'b1;
          state_nxt = (last_grant == GRANT_JTAG) ? A_ISSUE : J_ISSUE;
        end else if (slot_full) begin
          state_nxt = J_ISSUE;
        end else if (avs_cmd) begin
          state_nxt = A_ISSUE;
        end
      end
      J_ISSUE: begin
        ram_addr  = mon_a_reg;
        ram_we    = slot_wr;
        ram_wdata = slot_wdata;
        slot_take = 1'b1;
        state_nxt = slot_wr ? J_DONE : J_CAP;
      end
      J_CAP: begin
        state_nxt = J_DONE;
      end
      J_DONE: begin
        jtag_done = 1'b1;
        state_nxt = IDLE;
      end
      A_ISSUE: begin
        ram_addr = avs_address;
        if (avs_write) begin
          ram_we       = 1'b1;
          ram_wdata    = avs_writedata;
          avs_complete = 1'b1;
          state_nxt    = IDLE;
        end else if (avs_read) begin
          state_nxt = A_CAP;
        end else begin
          // Master withdrew its command; nothing to complete.
          state_nxt = IDLE;
        end
      end
      A_CAP: begin
        avs_complete = 1'b1;
        avs_readdata = ram_rdata;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign avs_waitrequest = avs_cmd & ~avs_complete;

endmodule

// File: tb/tb_niosqsys_ocimem_arbiter.sv
// Scoreboard bench for the OCI debug-memory arbiter with a behavioural RAM.
module tb_niosqsys_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        jtag_ld_addr;
  logic [7:0]  jtag_addr;
  logic        jtag_req;
  logic        jtag_wr;
  logic [31:0] jtag_wdata;
  logic        jtag_clr_err;
  logic [31:0] MonDReg;
  logic        jtag_done;
  logic        jtag_overrun;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] jd_q[$];

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  logic [31:0] md;

  logic [31:0] mem [256];
  logic        pre_en;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;

  always #5 clk = ~clk;

  niosqsys_ocimem_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .jtag_ld_addr    (jtag_ld_addr),
    .jtag_addr       (jtag_addr),
    .jtag_req        (jtag_req),
    .jtag_wr         (jtag_wr),
    .jtag_wdata      (jtag_wdata),
    .jtag_clr_err    (jtag_clr_err),
    .MonDReg         (MonDReg),
    .jtag_done       (jtag_done),
    .jtag_overrun    (jtag_overrun),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .ram_addr        (ram_addr),
    .ram_we          (ram_we),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata)
  );

  // Single-port RAM, one-cycle read latency, plus a bench preload port.
  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_en = 1'b1;
    step();
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    md = 32'h0;
  endtask

  // Scoreboard consumers: RAM writes, Avalon read completions, JTAG completions.
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt++;
      if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(e.a));
        chk("wr_data", ram_wdata, e.d);
      end
    end
    if (!reset && avs_read && !avs_waitrequest) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else chk("avs_rdata", avs_readdata, rd_q.pop_front());
    end
    if (jtag_done) begin
      done_cnt++;
      if (jd_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else chk("mon_d", MonDReg, jd_q.pop_front());
    end
  end

  // Full JTAG access from the request pulse, with per-cycle timing checks.
  task automatic jtag_op(input logic wr, input logic [31:0] wd, input logic [7:0] a_exp);
    jtag_req   = 1'b1;
    jtag_wr    = wr;
    jtag_wdata = wd;
    if (wr) wr_q.push_back('{a: a_exp, d: wd});
    jd_q.push_back(md);
    step();
    jtag_req     = 1'b0;
    jtag_ld_addr = 1'b0;
    @(negedge clk);
    chk("j_c1_done", 32'(jtag_done), 32'd0);
    step();
    @(negedge clk);
    chk("j_c2_we", 32'(ram_we), 32'(wr));
    chk("j_c2_addr", 32'(ram_addr), 32'(a_exp));
    step();
    @(negedge clk);
    chk("j_c3_done", 32'(jtag_done), 32'(wr));
    if (!wr) begin
      step();
      @(negedge clk);
      chk("j_c4_done", 32'(jtag_done), 32'd1);
    end
    step();
  endtask

  // Waits (bounded) for waitrequest low; latency counted from the current cycle.
  task automatic avs_wait(input string tag, input int exp_lat);
    int lat;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        lat = i;
        break;
      end
      step();
    end
    chk(tag, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int d0;
    int we0;
    reset = 1'b1; jtag_ld_addr = 1'b0; jtag_addr = '0; jtag_req = 1'b0;
    jtag_wr = 1'b0; jtag_wdata = '0; jtag_clr_err = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    pre_en = 1'b0; pre_a = '0; pre_d = '0; md = '0;

    do_reset();
    @(negedge clk);
    chk("rst_wait", 32'(avs_waitrequest), 32'd0);
    chk("rst_done", 32'(jtag_done), 32'd0);
    chk("rst_ovr", 32'(jtag_overrun), 32'd0);
    chk("rst_mond", MonDReg, 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    step();

    // JTAG write at a loaded address, then the incremented address.
    jtag_ld_addr = 1'b1; jtag_addr = 8'h10;
    step();
    jtag_ld_addr = 1'b0;
    jtag_op(1'b1, 32'hDEADBEEF, 8'h10);
    jtag_op(1'b1, 32'hA5A50011, 8'h11);

    // JTAG read at 0xFF, then wrap to 0x00.
    preload(8'hFF, 32'h12345678);
    jtag_ld_addr = 1'b1; jtag_addr = 8'hFF;
    step();
    jtag_ld_addr = 1'b0;
    md = 32'h12345678;
    jtag_op(1'b0, 32'h0, 8'hFF);
    jtag_op(1'b1, 32'h0000CAFE, 8'h00);

    // Load and request in the same cycle: request uses the new address.
    jtag_ld_addr = 1'b1; jtag_addr = 8'h55;
    jtag_op(1'b1, 32'h55550055, 8'h55);

    // Collisions as seen by IDLE: slot full and Avalon command together.
    do_reset();
    preload(8'h00, 32'hC0FFEE00);
    preload(8'h20, 32'h20202020);
    preload(8'h21, 32'h21212121);
    md = 32'hC0FFEE00;
    jd_q.push_back(md);
    jtag_req = 1'b1; jtag_wr = 1'b0;
    step();
    jtag_req = 1'b0;
    avs_read = 1'b1; avs_address = 8'h20;
    rd_q.push_back(32'h20202020);
    d0 = done_cnt;
    avs_wait("col1_lat", 6);
    chk("col1_jtag_first", 32'(done_cnt), 32'(d0 + 1));
    step();
    avs_read = 1'b0;

    jd_q.push_back(md);
    wr_q.push_back('{a: 8'h01, d: 32'h5555AAAA});
    jtag_req = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h5555AAAA;
    step();
    jtag_req = 1'b0;
    avs_read = 1'b1; avs_address = 8'h21;
    rd_q.push_back(32'h21212121);
    d0 = done_cnt;
    avs_wait("col2_lat", 2);
    chk("col2_avs_first", 32'(done_cnt), 32'(d0));
    step();
    avs_read = 1'b0;
    repeat (4) step();
    chk("col2_jtag_after", 32'(done_cnt), 32'(d0 + 1));

    // Overrun: second request while the first is pending.
    we0 = we_cnt;
    jd_q.push_back(md);
    wr_q.push_back('{a: 8'h02, d: 32'h0BADF00D});
    jtag_req = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h0BADF00D;
    step();
    jtag_wdata = 32'h11111111;
    step();
    jtag_req = 1'b0;
    @(negedge clk);
    chk("ovr_set", 32'(jtag_overrun), 32'd1);
    repeat (4) step();
    chk("ovr_one_access", 32'(we_cnt), 32'(we0 + 1));
    jtag_clr_err = 1'b1;
    step();
    jtag_clr_err = 1'b0;
    @(negedge clk);
    chk("ovr_clr", 32'(jtag_overrun), 32'd0);
    step();

    // Drop coinciding with clear: set wins.
    jd_q.push_back(md);
    wr_q.push_back('{a: 8'h03, d: 32'h22222222});
    jtag_req = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h22222222;
    step();
    jtag_clr_err = 1'b1;
    step();
    jtag_req = 1'b0; jtag_clr_err = 1'b0;
    @(negedge clk);
    chk("ovr_set_wins", 32'(jtag_overrun), 32'd1);
    repeat (4) step();
    jtag_clr_err = 1'b1;
    step();
    jtag_clr_err = 1'b0;

    // Uncontended Avalon write then read-back.
    avs_write = 1'b1; avs_address = 8'h40; avs_writedata = 32'hFEEDFACE;
    wr_q.push_back('{a: 8'h40, d: 32'hFEEDFACE});
    avs_wait("avw_lat", 1);
    chk("avw_wdata", ram_wdata, 32'hFEEDFACE);
    chk("avw_rdata_zero", avs_readdata, 32'd0);
    step();
    avs_write = 1'b0;
    avs_read = 1'b1; avs_address = 8'h40;
    rd_q.push_back(32'hFEEDFACE);
    avs_wait("avr_lat", 2);
    step();
    avs_read = 1'b0;

    // Reset in A_CAP with the read held; re-served after release.
    preload(8'h30, 32'h30303030);
    avs_read = 1'b1; avs_address = 8'h30;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    md = 32'h0;
    rd_q.push_back(32'h30303030);
    avs_wait("rst_reserve_lat", 2);
    step();
    avs_read = 1'b0;

    // MonAReg returns to zero after reset.
    jtag_op(1'b1, 32'h0F0F0F0F, 8'h00);

    repeat (2) step();
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("jd_q_empty", 32'(jd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
